boot_mem: RTL

Parametrised boot memory for the SoC processor. Low addresses hold a boot image that is loaded on reset and is read-only afterwards. The remaining words are writable scratch RAM. Adds several features to the fixed 16x16 boot ROM:
- registered reads with a valid strobe
- a sticky write-lock
- a write-error flag
- a hardware clear engine that zeroes the RAM region one word per cycle

---
 rtl/boot_mem.sv | 131 +++++++++++++
 1 files changed

// File: rtl/boot_mem.sv
// Boot memory: reset-loaded read-only boot image in low words, writable scratch RAM above it,
// with registered reads, sticky write-lock, write-error pulse and a word-per-cycle clear engine.
module boot_mem #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ROM_WORDS = 7,
  parameter logic [ROM_WORDS*DATA_W-1:0] INIT_IMAGE = {16'h4000, 16'h3007, 16'hF400, 16'h1007,
                                                      16'hF800, 16'h4000, 16'hF200}
) (
  input  logic              romclk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              ready,
  input  logic              clr_req,
  output logic              busy,
  input  logic              lock,
  output logic              locked,
  output logic              werr
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned ImgW  = Depth * DATA_W;
  // Image zero-extended to the full array, so RAM words reset to zero by the same loop.
  localparam logic [ImgW-1:0]   ImagePad = ImgW'(INIT_IMAGE);
  localparam logic [ADDR_W:0]   RomEnd   = (ADDR_W + 1)'(ROM_WORDS);
  localparam logic [ADDR_W:0]   LastPtr  = (ADDR_W + 1)'(Depth - 1);
  localparam bit                HasRam   = (ROM_WORDS < Depth);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  logic [DATA_W-1:0] mem_q [Depth];
  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rvalid_q, rvalid_d;
  logic              locked_q, locked_d;
  logic              werr_q, werr_d;

  logic acc, rd_acc, wr_acc, rom_hit, wr_en, wr_rej, clr_en, clr_rej;

  assign busy    = (state_q == StClear);
  assign ready   = ~busy;
  assign acc     = cs & ready;
  assign rd_acc  = acc & ~we;
  assign wr_acc  = acc & we;
  assign rom_hit = ({1'b0, addr} < RomEnd);
  assign wr_en   = wr_acc & ~rom_hit & ~locked_q;
  assign wr_rej  = wr_acc & (rom_hit | locked_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    clr_rej = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          if (locked_q) begin
            clr_rej = 1'b1;
          end else if (HasRam) begin
            state_d = StClear;
            ptr_d   = RomEnd;
          end
        end
      end
      StClear: begin
        clr_en = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LastPtr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dout_d   = dout_q;
    rvalid_d = rd_acc;
    locked_d = locked_q | lock;
    werr_d   = wr_rej | clr_rej;
    if (rd_acc) begin
      dout_d = mem_q[addr];
    end
  end

  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= RomEnd;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      locked_q <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      locked_q <= locked_d;
      werr_q   <= werr_d;
    end
  end

  // Host writes and clear writes are mutually exclusive: host access needs ready, clear needs busy.
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= ImagePad[i*DATA_W +: DATA_W];
      end
    end else begin
      if (wr_en) begin
        mem_q[addr] <= din;
      end
      if (clr_en) begin
        mem_q[ptr_q[ADDR_W-1:0]] <= '0;
      end
    end
  end

  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign locked = locked_q;
  assign werr   = werr_q;

endmodule
